// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: command codes, FSM states, flag bit positions.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    XOR  = 3'b010,
    SLT  = 3'b011,
    AND  = 3'b100,
    NAND = 3'b101,
    NOR  = 3'b110,
    OR   = 3'b111
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, responder and ALU-side signals of the shared-ALU arbiter.
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cmd, req1_cmd,
    input  rsp0_ready, rsp1_ready, alu_result, alu_carryout, alu_zero, alu_overflow,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    output alu_a, alu_b, alu_cmd, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cmd, req1_cmd,
    output rsp0_ready, rsp1_ready, alu_result, alu_carryout, alu_zero, alu_overflow,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    input  alu_a, alu_b, alu_cmd, busy
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant; the pointer holder wins ties, pointer moves only on advance.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       adv_to_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);
  logic ptr_q, ptr_d;

  assign ptr_d = adv_i ? adv_to_i : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
endmodule

// File: rtl/alu_arbiter.sv
// Grants one requester to the external ALU, holds operands for SETTLE_CYCLES, then returns the result.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q;
  logic [31:0]   a_q, b_q, res_q;
  logic [2:0]    cmd_q, flags_q;
  logic          gnt_vld, gnt_idx, accept, capture, rsp_rdy, rsp_fire;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({bus.req1_valid, bus.req0_valid}),
    .adv_i     (rsp_fire),
    .adv_to_i  (~owner_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign capture  = (state_q == SETTLE) && (cnt_q == '0);
  assign rsp_rdy  = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign rsp_fire = (state_q == RESP) && rsp_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (gnt_vld) begin
                state_d = SETTLE;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
              end
      SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
              else             state_d = RESP;
      RESP:   if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is held low during reset even though the state may still read IDLE.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = (state_q == RESP) && !owner_q;
    bus.rsp1_valid = (state_q == RESP) &&  owner_q;
    bus.busy       = (state_q != IDLE);
    if (rst_n && accept) begin
      bus.req0_ready = !gnt_idx;
      bus.req1_ready =  gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        owner_q <= gnt_idx;
        a_q     <= gnt_idx ? bus.req1_a   : bus.req0_a;
        b_q     <= gnt_idx ? bus.req1_b   : bus.req0_b;
        cmd_q   <= gnt_idx ? bus.req1_cmd : bus.req0_cmd;
      end
      if (capture) begin
        res_q              <= bus.alu_result;
        flags_q[FLAG_CARRY] <= bus.alu_carryout;
        flags_q[FLAG_ZERO]  <= bus.alu_zero;
        flags_q[FLAG_OVF]   <= bus.alu_overflow;
      end
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_cmd    = cmd_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: slow behavioural ALU, directed scenarios and randomized two-requester traffic.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int S   = 4;
  localparam int THR = (S - 1) * 10 + 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  alu_arbiter_if intf();

  alu_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  // {carry, zero, ovf, result} from the arithmetic definition of each command
  function automatic logic [34:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy, ov;
    cy = 1'b0; ov = 1'b0; s = '0;
    case (c)
      ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SLT: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
        if (c == SLT) r = {31'd0, ($signed(a) < $signed(b))};
      end
      XOR:  r = a ^ b;
      AND:  r = a & b;
      NAND: r = ~(a & b);
      NOR:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {cy, (r == 32'd0), ov, r};
  endfunction

  // ALU with propagation delay: outputs are garbage until inputs have been stable long enough
  logic [66:0] alu_seen = 'x;
  time         alu_t = 0;
  logic [34:0] alu_out;
  always @(intf.alu_a or intf.alu_b or intf.alu_cmd or negedge clk) begin
    if ({intf.alu_cmd, intf.alu_a, intf.alu_b} !== alu_seen) begin
      alu_seen = {intf.alu_cmd, intf.alu_a, intf.alu_b};
      alu_t    = $time;
    end
    alu_out = alu_ref(intf.alu_cmd, intf.alu_a, intf.alu_b);
    if (($time - alu_t) < THR) alu_out = ~alu_out;
    intf.alu_result   = alu_out[31:0];
    intf.alu_carryout = alu_out[34];
    intf.alu_zero     = alu_out[33];
    intf.alu_overflow = alu_out[32];
  end

  task automatic send(input int n, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin intf.req0_valid = 1'b1; intf.req0_cmd = c; intf.req0_a = a; intf.req0_b = b; end
    else        begin intf.req1_valid = 1'b1; intf.req1_cmd = c; intf.req1_a = a; intf.req1_b = b; end
  endtask

  task automatic drop(input int n);
    if (n == 0) intf.req0_valid = 1'b0;
    else        intf.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output int lat);
    lat = 0;
    while (((n == 0) ? intf.rsp0_valid : intf.rsp1_valid) !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_rsp(input int n);
    if (n == 0) intf.rsp0_ready = 1'b1; else intf.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    intf.req0_valid = 1'b0; intf.req1_valid = 1'b0;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
    send(0, ADD, 32'h1, 32'h2); send(1, OR, 32'h3, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (intf.req0_ready !== 1'b0) $display("FAIL reset_rdy0: got %b want 0", intf.req0_ready); else n_pass++;
    n_chk++; if (intf.req1_ready !== 1'b0) $display("FAIL reset_rdy1: got %b want 0", intf.req1_ready); else n_pass++;
    n_chk++; if (intf.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", intf.busy); else n_pass++;
    n_chk++; if ({intf.alu_a, intf.alu_b, intf.alu_cmd} !== 67'd0) $display("FAIL reset_alu: got %h want 0", {intf.alu_a, intf.alu_b, intf.alu_cmd}); else n_pass++;
    n_chk++; if ({intf.rsp_result, intf.rsp_flags} !== 35'd0) $display("FAIL reset_rsp: got %h want 0", {intf.rsp_result, intf.rsp_flags}); else n_pass++;
    n_chk++; if ({intf.rsp0_valid, intf.rsp1_valid} !== 2'b00) $display("FAIL reset_rspv: got %b want 00", {intf.rsp0_valid, intf.rsp1_valid}); else n_pass++;
    drop(0); drop(1);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    do_reset();
    send(0, ADD, 32'd5, 32'd7); #1;
    n_chk++; if (intf.req0_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", intf.req0_ready); else n_pass++;
    @(posedge clk); #1; drop(0);
    n_chk++; if ({intf.alu_a, intf.alu_b, intf.alu_cmd} !== {32'd5, 32'd7, 3'b000}) $display("FAIL basic_alu_in: got %h want %h", {intf.alu_a, intf.alu_b, intf.alu_cmd}, {32'd5, 32'd7, 3'b000}); else n_pass++;
    n_chk++; if (intf.busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", intf.busy); else n_pass++;
    wait_rsp(0, lat);
    n_chk++; if (lat !== S) $display("FAIL basic_latency: got %0d want %0d", lat, S); else n_pass++;
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== {3'b000, 32'd12}) $display("FAIL basic_result: got %h want %h", {intf.rsp_flags, intf.rsp_result}, {3'b000, 32'd12}); else n_pass++;
    n_chk++; if (intf.rsp1_valid !== 1'b0) $display("FAIL basic_rsp1: got %b want 0", intf.rsp1_valid); else n_pass++;
    finish_rsp(0);
    n_chk++; if ({intf.busy, intf.rsp0_valid} !== 2'b00) $display("FAIL basic_done: got %b want 00", {intf.busy, intf.rsp0_valid}); else n_pass++;
  endtask

  task automatic test_arbitration();
    int lat;
    do_reset();
    send(0, SUB, 32'd3, 32'd3); send(1, SLT, 32'hFFFF_FFFF, 32'd1); #1;
    n_chk++; if ({intf.req0_ready, intf.req1_ready} !== 2'b10) $display("FAIL arb_first_grant: got %b want 10", {intf.req0_ready, intf.req1_ready}); else n_pass++;
    @(posedge clk); #1; drop(0);
    wait_rsp(0, lat);
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== {3'b110, 32'd0}) $display("FAIL arb_sub: got %h want %h", {intf.rsp_flags, intf.rsp_result}, {3'b110, 32'd0}); else n_pass++;
    finish_rsp(0);
    n_chk++; if ({intf.req0_ready, intf.req1_ready} !== 2'b01) $display("FAIL arb_second_grant: got %b want 01", {intf.req0_ready, intf.req1_ready}); else n_pass++;
    @(posedge clk); #1; drop(1);
    wait_rsp(1, lat);
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== {3'b100, 32'd1}) $display("FAIL arb_slt: got %h want %h", {intf.rsp_flags, intf.rsp_result}, {3'b100, 32'd1}); else n_pass++;
    finish_rsp(1);
  endtask

  task automatic test_overflow();
    int lat;
    send(1, ADD, 32'h7FFF_FFFF, 32'd1); #1;
    n_chk++; if (intf.req1_ready !== 1'b1) $display("FAIL ovf_ready: got %b want 1", intf.req1_ready); else n_pass++;
    @(posedge clk); #1; drop(1);
    wait_rsp(1, lat);
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== {3'b001, 32'h8000_0000}) $display("FAIL ovf_result: got %h want %h", {intf.rsp_flags, intf.rsp_result}, {3'b001, 32'h8000_0000}); else n_pass++;
    finish_rsp(1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] a0, b0, a1, b1;
    logic [34:0] e0, e1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    e0 = alu_ref(ADD, a0, b0); e1 = alu_ref(XOR, a1, b1);
    do_reset();
    send(0, ADD, a0, b0); send(1, XOR, a1, b1);
    @(posedge clk); #1; drop(0);
    wait_rsp(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++; if ({intf.rsp0_valid, intf.busy, intf.req1_ready} !== 3'b110) $display("FAIL bp_hold_ctl: got %b want 110", {intf.rsp0_valid, intf.busy, intf.req1_ready}); else n_pass++;
      n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== e0) $display("FAIL bp_hold_result: got %h want %h", {intf.rsp_flags, intf.rsp_result}, e0); else n_pass++;
    end
    finish_rsp(0);
    n_chk++; if (intf.req1_ready !== 1'b1) $display("FAIL bp_next_ready: got %b want 1", intf.req1_ready); else n_pass++;
    @(posedge clk); #1; drop(1);
    n_chk++; if (intf.alu_a !== a1) $display("FAIL bp_next_alu_a: got %h want %h", intf.alu_a, a1); else n_pass++;
    wait_rsp(1, lat);
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== e1) $display("FAIL bp_next_result: got %h want %h", {intf.rsp_flags, intf.rsp_result}, e1); else n_pass++;
    finish_rsp(1);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    do_reset();
    send(0, AND, $urandom, $urandom);
    @(posedge clk); #1; drop(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({intf.busy, intf.rsp0_valid, intf.rsp1_valid} !== 3'b000) $display("FAIL mid_rst_ctl: got %b want 000", {intf.busy, intf.rsp0_valid, intf.rsp1_valid}); else n_pass++;
    n_chk++; if ({intf.alu_a, intf.alu_b, intf.alu_cmd, intf.rsp_result, intf.rsp_flags} !== 102'd0) $display("FAIL mid_rst_data: got %h want 0", {intf.alu_a, intf.alu_b, intf.alu_cmd, intf.rsp_result, intf.rsp_flags}); else n_pass++;
    rst_n = 1'b1;
    intf.rsp0_ready = 1'b1; intf.rsp1_ready = 1'b1;
    seen = 1'b0;
    repeat (S + 4) begin
      @(posedge clk); #1;
      if (intf.rsp0_valid !== 1'b0 || intf.rsp1_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL mid_rst_no_rsp: got %b want 0", seen); else n_pass++;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
    send(1, OR, 32'hF0, 32'h0F);
    @(posedge clk); #1; drop(1);
    wait_rsp(1, lat);
    n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== {3'b000, 32'hFF}) $display("FAIL mid_rst_or: got %h want %h", {intf.rsp_flags, intf.rsp_result}, {3'b000, 32'hFF}); else n_pass++;
    finish_rsp(1);
  endtask

  // Transaction-level model: pointer holder wins, op occupies S settle cycles then one response phase.
  task automatic traffic(input int nops, input int p_req, input int p_rdy, input bit b2b);
    bit          pend [2];
    logic [2:0]  pc [2];
    logic [31:0] pa [2], pb [2];
    logic [34:0] exp_r;
    logic [66:0] exp_in;
    bit idle, resp, rr;
    int ptr, owner, cnt, done, cyc, win, last_win, last_acc;
    idle = 1; resp = 0; ptr = 0; owner = 0; cnt = 0; done = 0; cyc = 0;
    last_win = -1; last_acc = 0; exp_r = '0; exp_in = '0;
    pend[0] = 0; pend[1] = 0;
    while (done < nops && cyc < 3000) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && (b2b || $urandom_range(99) < p_req)) begin
          pend[i] = 1; pc[i] = 3'($urandom_range(7)); pa[i] = $urandom; pb[i] = $urandom;
          if ($urandom_range(3) == 0) pb[i] = pa[i];
        end
      intf.req0_valid = pend[0]; intf.req0_cmd = pc[0]; intf.req0_a = pa[0]; intf.req0_b = pb[0];
      intf.req1_valid = pend[1]; intf.req1_cmd = pc[1]; intf.req1_a = pa[1]; intf.req1_b = pb[1];
      rr = b2b || ($urandom_range(99) < p_rdy);
      intf.rsp0_ready = rr; intf.rsp1_ready = rr;
      @(negedge clk);
      cyc++;
      win = -1;
      if (idle) begin
        if (pend[ptr]) win = ptr;
        else if (pend[1-ptr]) win = 1 - ptr;
      end
      n_chk++; if ({intf.req0_ready, intf.req1_ready} !== {win == 0, win == 1}) $display("FAIL trf_ready: got %b want %b cyc %0d", {intf.req0_ready, intf.req1_ready}, {win == 0, win == 1}, cyc); else n_pass++;
      n_chk++; if ({intf.rsp0_valid, intf.rsp1_valid, intf.busy} !== {resp && owner == 0, resp && owner == 1, !idle}) $display("FAIL trf_rsp_ctl: got %b want %b cyc %0d", {intf.rsp0_valid, intf.rsp1_valid, intf.busy}, {resp && owner == 0, resp && owner == 1, !idle}, cyc); else n_pass++;
      if (!idle) begin
        n_chk++; if ({intf.alu_cmd, intf.alu_a, intf.alu_b} !== exp_in) $display("FAIL trf_alu_in: got %h want %h", {intf.alu_cmd, intf.alu_a, intf.alu_b}, exp_in); else n_pass++;
      end
      if (resp) begin
        n_chk++; if ({intf.rsp_flags, intf.rsp_result} !== exp_r) $display("FAIL trf_result: got %h want %h", {intf.rsp_flags, intf.rsp_result}, exp_r); else n_pass++;
      end
      if (win >= 0) begin
        if (b2b && last_win >= 0) begin
          n_chk++; if (win == last_win || cyc - last_acc != S + 2) $display("FAIL b2b_alternate: got grant %0d gap %0d want grant %0d gap %0d", win, cyc - last_acc, 1 - last_win, S + 2); else n_pass++;
        end
        last_win = win; last_acc = cyc;
        owner = win; idle = 0; cnt = S; pend[win] = 0;
        exp_in = {pc[win], pa[win], pb[win]};
        exp_r  = alu_ref(pc[win], pa[win], pb[win]);
      end else if (resp) begin
        if (rr) begin resp = 0; idle = 1; ptr = 1 - owner; done++; end
      end else if (!idle) begin
        cnt--;
        if (cnt == 0) resp = 1;
      end
      @(posedge clk); #1;
    end
    n_chk++; if (done != nops) $display("FAIL trf_timeout: got %0d ops want %0d", done, nops); else n_pass++;
    intf.req0_valid = 1'b0; intf.req1_valid = 1'b0;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    traffic(8, 100, 100, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    traffic(24, 30, 60, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    intf.req0_valid = 1'b0; intf.req1_valid = 1'b0;
    intf.req0_a = '0; intf.req0_b = '0; intf.req0_cmd = '0;
    intf.req1_a = '0; intf.req1_b = '0; intf.req1_cmd = '0;
    intf.rsp0_ready = 1'b0; intf.rsp1_ready = 1'b0;
    test_reset();
    test_basic();
    test_arbitration();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
